// File: rtl/rca_seq_pkg.sv
// rca_seq_pkg: shared state and opcode definitions for the multiword sequencer
package rca_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} rca_seq_state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: WIDTH-bit combinational ripple-carry adder
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout
);
  logic [WIDTH:0] c;
  assign c[0] = Cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign SUM[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign Cout = c[WIDTH];
endmodule

// File: rtl/rca_multiword_sequencer.sv
// rca_multiword_sequencer: wide add/subtract done one chunk per cycle through a shared adder
module rca_multiword_sequencer
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WORDS = 4,
  localparam int TW = WIDTH * WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [TW-1:0] a,
  input  logic [TW-1:0] b,
  input  logic          cin,
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] sum,
  output logic          cout
);
  localparam int IW = $clog2(WORDS) < 1 ? 1 : $clog2(WORDS);
  rca_seq_state_t state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [WIDTH-1:0] s;
  logic             co;
  int               lo;
  assign lo = int'(idx_q) * WIDTH;
  ripple_carry_adder #(.WIDTH(WIDTH)) u_rca (
    .A(a_q[lo +: WIDTH]),
    .B(b_q[lo +: WIDTH]),
    .Cin(carry_q),
    .SUM(s),
    .Cout(co)
  );
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  // next state: capture operands on start, fold one chunk per RUN cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = op == OP_SUB ? ~b : b;
        carry_d = op == OP_SUB ? 1'b1 : cin;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[lo +: WIDTH] = s;
        carry_d = co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(WORDS - 1)) begin
          cout_d  = co;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule

// File: doc/rca_multiword_sequencer.md
# rca_multiword_sequencer

Multi-cycle controller that computes WIDTH*WORDS-bit add/subtract results with a single WIDTH-bit `ripple_carry_adder` instance. It slices the operands into WORDS chunks, least significant chunk first, and feeds one chunk per cycle through the shared adder. It registers each partial sum and carries Cout into the next chunk. It trades latency for area and is the serial front-end for wide arithmetic in the datapath.

## Interface
Parameters:
- WIDTH, 4, bit width of the shared `ripple_carry_adder` (chunk width), ≥1
- WORDS, 4, number of chunks per operation, ≥2; total operand width TW = WIDTH*WORDS

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  0 = add (A+B+cin), 1 = subtract (A−B; cin ignored)
- a  in  TW  operand A, captured on accepted start
- b  in  TW  operand B, captured on accepted start
- cin  in  1  carry-in for add, captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, result valid
- sum  out  TW  result register
- cout  out  1  final carry out; for subtract, 1 means no borrow (A ≥ B unsigned)

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:** `busy`=0. On `start`=1:
  - latch `a` into a_q
  - latch `b` into b_q, or `~b` if `op`=1
  - set carry_q ← `cin` for add, 1 for subtract
  - clear idx ← 0, then go to RUN.
- **RUN:** the adder gets A=a_q[idx*WIDTH +: WIDTH], B=b_q[idx*WIDTH +: WIDTH], Cin=carry_q. At each edge:
  - sum[idx*WIDTH +: WIDTH] ← SUM
  - carry_q ← Cout
  - idx ← idx+1
  - When idx = WORDS−1, the edge also loads `cout` ← Cout and goes to DONE.
- **DONE:** `done`=1 for exactly one cycle, then unconditionally go to IDLE.
- `sum` and `cout` hold their value from DONE until the next accepted start. Chunks of `sum` update progressively during RUN and are not valid until `done`.
- `start` in RUN or DONE is ignored and not queued.
- All arithmetic is unsigned modulo 2^TW. `cout` is the carry out of bit TW−1.
- idx is a counter of $clog2(WORDS) bits (minimum 1) and never exceeds WORDS−1.
- The adder input mux is combinational from registered state, so no input of the adder comes from a port.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, idx=0, carry_q=0.
- Start accepted at edge E0. RUN occupies cycles E0+1 … E0+WORDS. `done`=1 in the cycle after edge E0+WORDS.
- Latency from start to done is WORDS+1 cycles; with the defaults, done is seen 5 cycles after start.
- Throughput is one operation per WORDS+2 cycles. A start asserted in the `done` cycle is ignored; the earliest acceptable start is the first cycle after `done`.
- `rst` at any cycle, including mid-RUN or in DONE, returns all state to reset values at that edge. No `done` pulse is produced for the aborted operation.
- `rst` and `start` in the same cycle: `rst` wins and `start` is dropped.

## Structure
- Shared package `rca_seq_pkg` holds:
  - state enum `rca_seq_state_t` {IDLE, RUN, DONE}
  - op encodings `OP_ADD`=1'b0, `OP_SUB`=1'b1.
- One sub-module: the existing `ripple_carry_adder #(WIDTH)` (ports A, B, Cin, SUM, Cout), instantiated once.
- Everything else lives in this module: FSM, counter, operand/carry registers, result register.

## Test plan
All scenarios use the defaults (WIDTH=4, WORDS=4).
- **Basic add:** op=0, a=16'h1234, b=16'h1111, cin=0 → `sum`=16'h2345, `cout`=0. `done` pulses exactly once, 5 cycles after start, and `busy` is high for 5 cycles.
- **Full carry ripple:** op=0, a=16'hFFFF, b=16'h0001, cin=0 → `sum`=16'h0000, `cout`=1. Also a=16'hFFFF, b=16'hFFFF, cin=1 → `sum`=16'hFFFF, `cout`=1.
- **Subtract:**
  - a=16'h1000, b=16'h0001, op=1 → `sum`=16'h0FFF, `cout`=1.
  - a=16'h0001, b=16'h0002, op=1 → `sum`=16'hFFFF, `cout`=0 (borrow).
- **Start while busy:** start with 16'h0005+16'h0003, then re-assert start with different operands in cycles 2 and 5 → result 16'h0008 only, single `done`. The next operation is accepted only after `done`.
- **Reset mid-operation:** start 16'hABCD+16'h1111, assert `rst` in the 2nd RUN cycle → next cycle `sum`=0, `cout`=0, `busy`=0, and no `done`. A fresh start then completes correctly.
- **Random sweep:** 1000 random a/b/op/cin compared to a behavioural TW-bit model, with back-to-back starts issued the cycle after each `done`.
